// File: rtl/timer_arbiter_pkg.sv
// Shared definitions for the timer arbiter: FSM state encoding, default timing
// constants and the round-robin pick helper.
package timer_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } state_e;

    localparam int unsigned DEF_PRESCALE = 50;
    localparam int unsigned DEF_TICKS    = 10;
    localparam int unsigned MAX_NREQ     = 8;

    // Lowest set bit at or above ptr; wraps to the lowest set bit overall.
    // Unused upper request bits must be zero.
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
        logic [7:0] masked;
        logic [7:0] src;
        logic [2:0] sel;
        masked = req & (8'hFF << ptr);
        src    = (masked != 8'h00) ? masked : req;
        sel    = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (src[i]) sel = 3'(i);
        end
        return sel;
    endfunction

endpackage

// File: rtl/timer_arbiter_tick_timer.sv
// Prescaled countdown timer: prescaler wraps every PRESCALE cycles and
// decrements a saturating tick counter that is reloaded by clear_i.
module tick_timer
    import timer_arbiter_pkg::*;
#(
    parameter int unsigned PRESCALE = DEF_PRESCALE,
    parameter int unsigned TICKS    = DEF_TICKS,
    parameter int unsigned TW       = $clog2(TICKS + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          enable_i,
    output logic          tick_o,
    output logic [TW-1:0] ticks_left_o,
    output logic          expire_o
);

    localparam int unsigned CW = $clog2(PRESCALE);

    logic [CW-1:0] pre_q, pre_d;
    logic [TW-1:0] ticks_q, ticks_d;
    logic          wrap;

    assign wrap         = (pre_q == CW'(PRESCALE - 1));
    assign tick_o       = enable_i && wrap;
    // High during the final tick period; the owner completes on the next tick.
    assign expire_o     = (ticks_q == TW'(1));
    assign ticks_left_o = ticks_q;

    always_comb begin
        pre_d   = pre_q;
        ticks_d = ticks_q;
        if (clear_i) begin
            pre_d   = '0;
            ticks_d = TW'(TICKS);
        end else if (enable_i) begin
            if (wrap) begin
                pre_d = '0;
                if (ticks_q != '0) ticks_d = ticks_q - 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_q   <= '0;
            ticks_q <= '0;
        end else begin
            pre_q   <= pre_d;
            ticks_q <= ticks_d;
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin owner selection for one shared countdown timer; grants, runs the
// interval and returns a one-cycle done pulse to the owner.
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned PRESCALE = DEF_PRESCALE,
    parameter int unsigned TICKS    = DEF_TICKS
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NREQ-1:0]                req_i,
    output logic [NREQ-1:0]                grant_o,
    output logic [NREQ-1:0]                done_o,
    output logic                           busy_o,
    output logic [$clog2(TICKS+1)-1:0]     ticks_left_o
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned TW = $clog2(TICKS + 1);

    state_e          state_q;
    logic [IW-1:0]   owner_q;
    logic [IW-1:0]   rr_ptr_q;
    logic [NREQ-1:0] grant_q;
    logic [NREQ-1:0] done_q;

    logic [2:0]      pick;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   owner_nxt;
    logic            owner_req;
    logic            tick;
    logic            expire;
    logic [TW-1:0]   timer_ticks;

    assign pick      = rr_pick(8'(req_i), 3'(rr_ptr_q));
    assign pick_idx  = IW'(pick);
    assign owner_req = req_i[owner_q];
    assign owner_nxt = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    tick_timer #(
        .PRESCALE (PRESCALE),
        .TICKS    (TICKS),
        .TW       (TW)
    ) u_tick_timer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (state_q == LOAD),
        .enable_i     (state_q == RUN),
        .tick_o       (tick),
        .ticks_left_o (timer_ticks),
        .expire_o     (expire)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            done_q   <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        owner_q <= pick_idx;
                        grant_q <= NREQ'(1) << pick_idx;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (!owner_req) begin
                        state_q  <= IDLE;
                        grant_q  <= '0;
                        rr_ptr_q <= owner_nxt;
                    end else begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // A dropped request beats a completion on the same cycle.
                    if (!owner_req) begin
                        state_q  <= IDLE;
                        grant_q  <= '0;
                        rr_ptr_q <= owner_nxt;
                    end else if (tick && expire) begin
                        state_q <= FIN;
                        done_q  <= grant_q;
                    end
                end
                FIN: begin
                    state_q  <= IDLE;
                    grant_q  <= '0;
                    rr_ptr_q <= owner_nxt;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        ticks_left_o = '0;
        case (state_q)
            IDLE:    ticks_left_o = '0;
            LOAD:    ticks_left_o = TW'(TICKS);
            default: ticks_left_o = timer_ticks;
        endcase
    end

    assign grant_o = grant_q;
    assign done_o  = done_q;
    assign busy_o  = |grant_q;

endmodule
